// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter: request fields in, grant and completion out.
// Requester holds req and fields stable until gnt; the request is accepted on the edge where req && gnt.
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (m0) and the loader (m1).
// Each access: grant in IDLE, MEM_LAT cycles of ACCESS, one RESP cycle carrying the rvalid pulse.
module data_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_arbiter_if.slave    m0,
  data_mem_arbiter_if.slave    m1,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_rr_last;
  logic          r_id;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_last;

  assign w_last = (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // r_rr_last = 1 means m1 was granted last, so m0 wins a tie.
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (reset) begin
          if (m0.req && (!m1.req || r_rr_last)) w_gnt0 = 1'b1;
          else if (m1.req)                      w_gnt1 = 1'b1;
          if (w_gnt0 || w_gnt1) w_next = S_ACCESS;
        end
      end
      S_ACCESS: if (w_last) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= 4'd0;
      r_rr_last <= 1'b1;
      r_id      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_gnt0 || w_gnt1) begin
        r_id      <= w_gnt1;
        r_rr_last <= w_gnt1;
        r_we      <= w_gnt1 ? m1.we    : m0.we;
        r_addr    <= w_gnt1 ? m1.addr  : m0.addr;
        r_wdata   <= w_gnt1 ? m1.wdata : m0.wdata;
        r_cnt     <= LAT_M1;
      end else if (r_state == S_ACCESS) begin
        if (w_last) begin
          r_rvalid0 <= !r_id;
          r_rvalid1 <= r_id;
          // Write completions leave the port's read data untouched.
          if (!r_we) begin
            if (r_id) r_rdata1 <= mem_rdata;
            else      r_rdata0 <= mem_rdata;
          end
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign m0.gnt    = w_gnt0;
  assign m1.gnt    = w_gnt1;
  assign m0.rvalid = r_rvalid0;
  assign m1.rvalid = r_rvalid1;
  assign m0.rdata  = r_rdata0;
  assign m1.rdata  = r_rdata1;

  assign mem_en      = (r_state == S_ACCESS);
  assign mem_we      = (r_state == S_ACCESS) && r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
